// File: rtl/bb_pkg.sv
// Shared play-entry types, action codes and game-shape constants for the baseball sequencer/scorer pair.
package bb_pkg;
  localparam logic [2:0] ACT_WALK      = 3'd0;
  localparam logic [2:0] ACT_SINGLE    = 3'd1;
  localparam logic [2:0] ACT_DOUBLE    = 3'd2;
  localparam logic [2:0] ACT_TRIPLE    = 3'd3;
  localparam logic [2:0] ACT_HOMER     = 3'd4;
  localparam logic [2:0] ACT_STRIKEOUT = 3'd5;
  localparam logic [2:0] ACT_GROUND    = 3'd6;
  localparam logic [2:0] ACT_FLY       = 3'd7;

  localparam logic [1:0] MAX_INNING    = 2'd3;
  localparam logic [2:0] LAST_HALF_IDX = 3'(2 * int'(MAX_INNING) - 1);

  localparam int ENTRY_W = 7;

  typedef struct packed {
    logic       eog;
    logic [1:0] inning;
    logic       half;
    logic [2:0] action;
  } play_entry_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SEND,
    RD_WAIT
  } rd_state_e;
endpackage

// File: rtl/bb_play_fifo.sv
// Game buffer: writes land above commit_ptr until the game commits; rollback rewinds wr_ptr to commit_ptr.
// Combinational read of the head entry, pop advances next cycle; occupancy counts committed + pending entries.
module bb_play_fifo import bb_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = ENTRY_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   occupancy
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  commit_ptr_q, commit_ptr_d;

  // Rollback wins over a same-cycle write so a dropped game leaves nothing behind.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, rd_en};
    if (rollback) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (commit) begin
      commit_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rollback) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
  end

  assign rd_dat    = mem_q[rd_ptr_q[AW-1:0]];
  assign occupancy = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bb_play_sequencer.sv
// Tags plays with inning/half, buffers whole games and replays each committed game as one burst (2 cycles after commit).
// s_ready drops only when the buffer is full; the next game waits for the scorer's bb_out_valid.
module bb_play_sequencer import bb_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_action,
  input  logic       s_eoh,
  input  logic       s_eog,
  output logic       in_valid,
  output logic [1:0] inning,
  output logic       half,
  output logic [2:0] action,
  input  logic       bb_out_valid,
  output logic       proto_err
);

  localparam logic [AW:0] FULL_OCC      = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_SLOT_OCC = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE           = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  occupancy;
  logic [2:0]   half_idx_q, half_idx_d;
  logic         discard_q, discard_d;
  logic [AW:0]  committed_q, committed_d;
  rd_state_e    state_q, state_d;
  logic         proto_err_q, proto_err_d;
  logic         in_valid_q, in_valid_d;
  logic [1:0]   inning_q, inning_d;
  logic         half_q, half_d;
  logic [2:0]   action_q, action_d;
  play_entry_t  wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_raw;
  logic         accept, wr_en, commit, rollback, game_done, game_pop;

  assign s_ready = (occupancy < FULL_OCC);
  assign accept  = s_valid && s_ready;

  always_comb begin
    wr_entry.eog    = s_eog;
    wr_entry.inning = 2'(half_idx_q >> 1) + 2'd1;
    wr_entry.half   = half_idx_q[0];
    wr_entry.action = s_action;
    wr_en       = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    game_done   = 1'b0;
    proto_err_d = 1'b0;
    half_idx_d  = half_idx_q;
    discard_d   = discard_q;
    if (accept) begin
      if (discard_q) begin
        // Tail of an overflowed game: swallow everything up to and including its end.
        if (s_eog) discard_d = 1'b0;
      end else if (s_eog) begin
        half_idx_d = '0;
        if (s_eoh && (half_idx_q == LAST_HALF_IDX || half_idx_q == LAST_HALF_IDX - 3'd1)) begin
          wr_en     = 1'b1;
          commit    = 1'b1;
          game_done = 1'b1;
        end else begin
          rollback    = 1'b1;
          proto_err_d = 1'b1;
        end
      end else if (s_eoh && half_idx_q == LAST_HALF_IDX) begin
        rollback    = 1'b1;
        proto_err_d = 1'b1;
        half_idx_d  = '0;
      end else if (committed_q == '0 && occupancy == LAST_SLOT_OCC) begin
        rollback    = 1'b1;
        proto_err_d = 1'b1;
        half_idx_d  = '0;
        discard_d   = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (s_eoh) half_idx_d = half_idx_q + 3'd1;
      end
    end
  end

  bb_play_fifo #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_dat    (wr_entry),
    .commit    (commit),
    .rollback  (rollback),
    .rd_en     (game_pop | (state_q == RD_SEND)),
    .rd_dat    (rd_raw),
    .occupancy (occupancy)
  );

  assign rd_entry = play_entry_t'(rd_raw);

  always_comb begin
    state_d    = state_q;
    game_pop   = 1'b0;
    in_valid_d = 1'b0;
    inning_d   = '0;
    half_d     = 1'b0;
    action_d   = '0;
    unique case (state_q)
      RD_IDLE: if (committed_q != '0) state_d = RD_SEND;
      RD_SEND: begin
        in_valid_d = 1'b1;
        inning_d   = rd_entry.inning;
        half_d     = rd_entry.half;
        action_d   = rd_entry.action;
        if (rd_entry.eog) begin
          game_pop = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: if (bb_out_valid) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    committed_d = committed_q;
    if (game_done && !game_pop) committed_d = committed_q + ONE;
    else if (!game_done && game_pop) committed_d = committed_q - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_idx_q  <= '0;
      discard_q   <= 1'b0;
      committed_q <= '0;
      state_q     <= RD_IDLE;
      proto_err_q <= 1'b0;
      in_valid_q  <= 1'b0;
      inning_q    <= '0;
      half_q      <= 1'b0;
      action_q    <= '0;
    end else begin
      half_idx_q  <= half_idx_d;
      discard_q   <= discard_d;
      committed_q <= committed_d;
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
      in_valid_q  <= in_valid_d;
      inning_q    <= inning_d;
      half_q      <= half_d;
      action_q    <= action_d;
    end
  end

  assign in_valid  = in_valid_q;
  assign inning    = inning_q;
  assign half      = half_q;
  assign action    = action_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bb_play_sequencer.sv
// Scoreboard bench for bb_play_sequencer: a 32-deep instance for game flows and reset, an 8-deep one for overflow.
module tb_bb_play_sequencer;
  import bb_pkg::*;

  typedef struct packed {
    logic       sel;
    logic [1:0] inning;
    logic       half;
    logic [2:0] action;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid_r [2];
  logic       s_eoh_r [2];
  logic       s_eog_r [2];
  logic       bb_out_valid_r [2];
  logic [2:0] s_action_r [2];
  logic       s_ready_w [2];
  logic       in_valid_w [2];
  logic       half_w [2];
  logic       proto_err_w [2];
  logic [1:0] inning_w [2];
  logic [2:0] action_w [2];

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_first [2] = '{-1, -1};
  int   games_done [2] = '{0, 0};
  int   beats_seen [2] = '{0, 0};
  int   proto_cnt [2] = '{0, 0};
  bit   in_burst [2] = '{0, 0};
  bit   prev_pe [2] = '{0, 0};

  bb_play_sequencer #(.DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_r[0]), .s_ready(s_ready_w[0]),
    .s_action(s_action_r[0]), .s_eoh(s_eoh_r[0]), .s_eog(s_eog_r[0]),
    .in_valid(in_valid_w[0]), .inning(inning_w[0]), .half(half_w[0]), .action(action_w[0]),
    .bb_out_valid(bb_out_valid_r[0]), .proto_err(proto_err_w[0])
  );

  bb_play_sequencer #(.DEPTH(8)) u_small (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_r[1]), .s_ready(s_ready_w[1]),
    .s_action(s_action_r[1]), .s_eoh(s_eoh_r[1]), .s_eog(s_eog_r[1]),
    .in_valid(in_valid_w[1]), .inning(inning_w[1]), .half(half_w[1]), .action(action_w[1]),
    .bb_out_valid(bb_out_valid_r[1]), .proto_err(proto_err_w[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic play(input int sel, input logic [2:0] act, input logic eoh, input logic eog);
    int n;
    n = 0;
    @(negedge clk);
    s_valid_r[sel]  = 1'b1;
    s_action_r[sel] = act;
    s_eoh_r[sel]    = eoh;
    s_eog_r[sel]    = eog;
    while (!s_ready_w[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL s_ready_wait dut%0d: s_ready stuck low for %0d cycles", sel, n);
    end
    @(posedge clk);
    #1;
    s_valid_r[sel] = 1'b0;
    s_eoh_r[sel]   = 1'b0;
    s_eog_r[sel]   = 1'b0;
  endtask

  // Plays of a game: per_half plays per half-inning, game ends on the last play of half nhalves-1.
  task automatic send_game(input int sel, input int nhalves, input int per_half, input int seed,
                           input bit ok, input bit lat);
    exp_t       pend [$];
    exp_t       e;
    logic [2:0] a;
    logic       eoh, eog;
    for (int h = 0; h < nhalves; h++) begin
      for (int p = 0; p < per_half; p++) begin
        a   = 3'((h * per_half + p + seed) % 8);
        eoh = (p == per_half - 1);
        eog = eoh && (h == nhalves - 1);
        play(sel, a, eoh, eog);
        e.sel    = sel[0];
        e.inning = 2'(h / 2 + 1);
        e.half   = h[0];
        e.action = a;
        e.last   = eog;
        pend.push_back(e);
      end
    end
    if (ok) begin
      foreach (pend[k]) exp_q.push_back(pend[k]);
      if (lat) exp_first[sel] = cyc + 2;
    end
  endtask

  task automatic wait_games(input int sel, input int target);
    int n;
    n = 0;
    while (games_done[sel] < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("games_done_dut%0d", sel), games_done[sel], target);
  endtask

  task automatic pulse_done(input int sel, input bit lat_next);
    bb_out_valid_r[sel] = 1'b1;
    @(posedge clk);
    #1;
    bb_out_valid_r[sel] = 1'b0;
    if (lat_next) exp_first[sel] = cyc + 2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          in_burst[i]  = 1'b0;
          prev_pe[i]   = 1'b0;
          exp_first[i] = -1;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (in_burst[i]) begin
            checks++;
            if (!in_valid_w[i]) begin
              failures++;
              $display("FAIL bubble dut%0d: in_valid=0 inside a game at cycle %0d, expected 1", i, cyc);
            end
          end
          if (in_valid_w[i]) begin
            beats_seen[i]++;
            if (!in_burst[i] && exp_first[i] >= 0) begin
              checks++;
              if (cyc != exp_first[i]) begin
                failures++;
                $display("FAIL latency dut%0d: first beat at cycle %0d, expected %0d", i, cyc, exp_first[i]);
              end
              exp_first[i] = -1;
            end
            checks++;
            if (exp_q.size() == 0 || exp_q[0].sel != i[0]) begin
              failures++;
              in_burst[i] = 1'b0;
              $display("FAIL beat dut%0d: unexpected beat inning=%0d half=%0d action=%0d, expected none",
                       i, inning_w[i], half_w[i], action_w[i]);
            end else begin
              e = exp_q.pop_front();
              if (inning_w[i] != e.inning || half_w[i] != e.half || action_w[i] != e.action) begin
                failures++;
                $display("FAIL beat dut%0d: got inning=%0d half=%0d action=%0d, expected inning=%0d half=%0d action=%0d",
                         i, inning_w[i], half_w[i], action_w[i], e.inning, e.half, e.action);
              end
              in_burst[i] = !e.last;
              if (e.last) games_done[i]++;
            end
          end else begin
            in_burst[i] = 1'b0;
          end
          if (proto_err_w[i]) begin
            proto_cnt[i]++;
            checks++;
            if (prev_pe[i]) begin
              failures++;
              $display("FAIL proto_err_width dut%0d: high for 2+ cycles, expected single pulse", i);
            end
          end
          prev_pe[i] = proto_err_w[i];
        end
      end
    end
  end

  initial begin : stimulus
    int b0, n;
    for (int i = 0; i < 2; i++) begin
      s_valid_r[i]      = 1'b0;
      s_eoh_r[i]        = 1'b0;
      s_eog_r[i]        = 1'b0;
      s_action_r[i]     = ACT_WALK;
      bb_out_valid_r[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle(3);
    chk("reset_in_valid", in_valid_w[0], 0);
    chk("reset_inning", inning_w[0], 0);
    chk("reset_half", half_w[0], 0);
    chk("reset_action", action_w[0], 0);
    chk("reset_proto_err", proto_err_w[0], 0);
    chk("reset_s_ready", s_ready_w[0], 1);
    chk("reset_s_ready_small", s_ready_w[1], 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("post_reset_in_valid", in_valid_w[0], 0);

    // Full game, 4 plays per half, ends at bottom of the 3rd.
    send_game(0, 6, 4, 0, 1'b1, 1'b1);
    wait_games(0, 1);
    pulse_done(0, 1'b0);
    chk("normal_proto_cnt", proto_cnt[0], 0);

    // Home side leads after top of the 3rd: game ends at half_idx 4.
    send_game(0, 5, 3, 3, 1'b1, 1'b1);
    wait_games(0, 2);
    pulse_done(0, 1'b0);

    // Game end claimed in top of the 2nd: dropped, then a clean game.
    send_game(0, 3, 2, 5, 1'b0, 1'b0);
    idle(4);
    chk("illegal_proto_cnt", proto_cnt[0], 1);
    send_game(0, 6, 1, 1, 1'b1, 1'b1);
    wait_games(0, 3);
    pulse_done(0, 1'b0);

    // Two games queued: the second must hold until the scorer answers.
    send_game(0, 6, 2, 2, 1'b1, 1'b1);
    send_game(0, 5, 2, 4, 1'b1, 1'b0);
    wait_games(0, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold_in_valid_%0d", k), in_valid_w[0], 0);
    end
    pulse_done(0, 1'b1);
    wait_games(0, 5);
    pulse_done(0, 1'b0);
    chk("b2b_proto_cnt", proto_cnt[0], 1);

    // 8-deep instance: 8 plays without an end overflow it.
    for (int k = 0; k < 8; k++) play(1, ACT_GROUND, 1'b0, 1'b0);
    idle(3);
    chk("overflow_proto_cnt", proto_cnt[1], 1);
    for (int k = 0; k < 3; k++) play(1, ACT_SINGLE, 1'b0, 1'b0);
    play(1, ACT_FLY, 1'b1, 1'b1);
    idle(4);
    chk("discard_proto_cnt", proto_cnt[1], 1);
    chk("overflow_s_ready", s_ready_w[1], 1);
    chk("overflow_in_valid", in_valid_w[1], 0);
    send_game(1, 6, 1, 6, 1'b1, 1'b1);
    wait_games(1, 1);
    pulse_done(1, 1'b0);

    // Reset part-way through a 12-beat burst.
    send_game(0, 6, 2, 3, 1'b1, 1'b1);
    b0 = beats_seen[0];
    n = 0;
    while (beats_seen[0] < b0 + 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("beats_before_reset", beats_seen[0] - b0, 5);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_in_valid", in_valid_w[0], 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    chk("after_reset_in_valid", in_valid_w[0], 0);
    chk("after_reset_s_ready", s_ready_w[0], 1);
    chk("after_reset_s_ready_small", s_ready_w[1], 1);
    send_game(0, 6, 1, 7, 1'b1, 1'b1);
    wait_games(0, 6);
    pulse_done(0, 1'b0);
    chk("final_proto_cnt", proto_cnt[0], 1);
    chk("final_proto_cnt_small", proto_cnt[1], 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
